// File: rtl/fpu_wb_arbiter_pkg.sv
// Shared FPU definitions: source indices, flag bit positions, the packed
// single-precision layout and the round-robin index helper.
package fpu_wb_arbiter_pkg;

    // Default number of result sources and default destination tag width
    localparam int N_REQ_DEF = 3;
    localparam int TAG_W_DEF = 5;

    // Result source indices
    localparam int SRC_ADD = 0;
    localparam int SRC_MUL = 1;
    localparam int SRC_DIV = 2;

    // IEEE exception flag bit positions within the 5-bit {NV,DZ,OF,UF,NX} field
    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;
    localparam int FLAG_W  = 5;

    // Packed IEEE 754 single-precision word
    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] man;
    } fp32_t;

    // Candidate index 'offs' steps after 'base', wrapping modulo n
    function automatic int rr_index(input int base, input int offs, input int n);
        int s;
        s = base + offs;
        if (s >= n) begin
            s = s - n;
        end
        return s;
    endfunction

endpackage

// File: rtl/fpu_wb_arbiter_pack.sv
// fpu_pack: assembles sign, exponent and mantissa into a 32-bit single word.
// Fields are concatenated bit-exact; no rounding or special-value handling.
module fpu_pack
    import fpu_wb_arbiter_pkg::*;
(
    input  logic        sign_i,
    input  logic [7:0]  exp_i,
    input  logic [22:0] man_i,
    output logic [31:0] data_o
);

    fp32_t word;

    // Plain field concatenation into the IEEE layout
    always_comb begin
        word.sign = sign_i;
        word.exp  = exp_i;
        word.man  = man_i;
        data_o    = word;
    end

endmodule

// File: rtl/fpu_wb_arbiter.sv
// fpu_wb_arbiter: round-robin writeback arbiter for FPU result sources.
// One output register; accepts a new result whenever it is empty or being
// drained, so a continuous stream sustains one result per cycle.
module fpu_wb_arbiter
    import fpu_wb_arbiter_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ-1:0]       req_sign,
    input  logic [8*N_REQ-1:0]     req_exp,
    input  logic [23*N_REQ-1:0]    req_man,
    input  logic [TAG_W*N_REQ-1:0] req_tag,
    input  logic [5*N_REQ-1:0]     req_flags,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_data,
    output logic [TAG_W-1:0]       out_tag,
    output logic [4:0]             out_flags,
    output logic [1:0]             out_src
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             out_valid_q, out_valid_d;
    logic [31:0]      out_data_q, out_data_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic [4:0]       out_flags_q, out_flags_d;
    logic [1:0]       out_src_q, out_src_d;

    logic             load;
    logic             handshake;
    logic             grant_found;
    logic [PTR_W-1:0] grant_idx;
    logic             sel_sign;
    logic [7:0]       sel_exp;
    logic [22:0]      sel_man;
    logic [31:0]      pack_data;

    // Output register can take a new result when empty or being consumed
    assign load      = !out_valid_q || out_ready;
    assign handshake = rst_n && load && grant_found;

    // Cyclic search from rr_ptr for the first valid source
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!grant_found && req_valid[rr_index(int'(rr_ptr_q), k, N_REQ)]) begin
                grant_found = 1'b1;
                grant_idx   = PTR_W'(rr_index(int'(rr_ptr_q), k, N_REQ));
            end
        end
    end

    // One-hot ready for the granted source; suppressed in reset
    always_comb begin
        req_ready = '0;
        if (handshake) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Select the granted source's floating-point fields
    always_comb begin
        sel_sign = req_sign[grant_idx];
        sel_exp  = req_exp[8*int'(grant_idx) +: 8];
        sel_man  = req_man[23*int'(grant_idx) +: 23];
    end

    fpu_pack u_pack (
        .sign_i (sel_sign),
        .exp_i  (sel_exp),
        .man_i  (sel_man),
        .data_o (pack_data)
    );

    // Next-state: refill on handshake, otherwise hold; drain clears valid
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_tag_d   = out_tag_q;
        out_flags_d = out_flags_q;
        out_src_d   = out_src_q;
        if (load) begin
            out_valid_d = grant_found;
        end
        if (handshake) begin
            out_data_d  = pack_data;
            out_tag_d   = req_tag[TAG_W*int'(grant_idx) +: TAG_W];
            out_flags_d = req_flags[5*int'(grant_idx) +: 5];
            out_src_d   = 2'(grant_idx);
            rr_ptr_d    = PTR_W'(rr_index(int'(grant_idx), 1, N_REQ));
        end
    end

    // Output register and round-robin pointer, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
            out_flags_q <= '0;
            out_src_q   <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_tag_q   <= out_tag_d;
            out_flags_q <= out_flags_d;
            out_src_q   <= out_src_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;
    assign out_flags = out_flags_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_fpu_wb_arbiter.sv
// Directed testbench for fpu_wb_arbiter with hand-computed expectations.
module tb_fpu_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [2:0]  req_sign;
    logic [23:0] req_exp;
    logic [68:0] req_man;
    logic [14:0] req_tag;
    logic [14:0] req_flags;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_tag;
    logic [4:0]  out_flags;
    logic [1:0]  out_src;

    int n_total;
    int n_bad;

    // Expected packed words per source (hand-computed)
    logic [31:0] exp_word [3];
    logic [4:0]  exp_tag  [3];
    logic [4:0]  exp_flg  [3];

    fpu_wb_arbiter #(.N_REQ(3), .TAG_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_sign  (req_sign),
        .req_exp   (req_exp),
        .req_man   (req_man),
        .req_tag   (req_tag),
        .req_flags (req_flags),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_flags (out_flags),
        .out_src   (out_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_total++;
        if (obs !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, want);
        end else begin
            $display("ok   %s = %0h", tag, obs);
        end
    endtask

    task automatic set_src(input int i, input logic s, input logic [7:0] e,
                           input logic [22:0] m, input logic [4:0] t, input logic [4:0] f);
        req_sign[i]          = s;
        req_exp[8*i +: 8]    = e;
        req_man[23*i +: 23]  = m;
        req_tag[5*i +: 5]    = t;
        req_flags[5*i +: 5]  = f;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Check the held output against the expected source
    task automatic check_out(input string tag, input int s);
        check_eq({tag, " out_valid"}, 64'(out_valid), 64'd1);
        check_eq({tag, " out_src"},   64'(out_src),   64'(s));
        check_eq({tag, " out_data"},  64'(out_data),  64'(exp_word[s]));
    endtask

    initial begin
        n_total   = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        req_valid = 3'b000;
        req_sign  = '0;
        req_exp   = '0;
        req_man   = '0;
        req_tag   = '0;
        req_flags = '0;
        out_ready = 1'b1;

        set_src(0, 1'b1, 8'h80, 23'h400000, 5'd3,  5'b00001);
        set_src(1, 1'b0, 8'h7F, 23'h000000, 5'd7,  5'b00100);
        set_src(2, 1'b0, 8'h81, 23'h200000, 5'd31, 5'b10000);
        exp_word[0] = 32'hC040_0000; exp_tag[0] = 5'd3;  exp_flg[0] = 5'b00001;
        exp_word[1] = 32'h3F80_0000; exp_tag[1] = 5'd7;  exp_flg[1] = 5'b00100;
        exp_word[2] = 32'h40A0_0000; exp_tag[2] = 5'd31; exp_flg[2] = 5'b10000;

        // Reset state, with requests present
        req_valid = 3'b111;
        @(negedge clk);
        check_eq("rst out_valid", 64'(out_valid), 64'd0);
        check_eq("rst out_data",  64'(out_data),  64'd0);
        check_eq("rst req_ready", 64'(req_ready), 64'd0);
        req_valid = 3'b000;
        rst_n = 1'b1;

        // Single result from source 0
        @(negedge clk);
        req_valid = 3'b001;
        #1 check_eq("t1 req_ready", 64'(req_ready), 64'b001);
        @(negedge clk);
        check_out("t1", 0);
        check_eq("t1 out_tag", 64'(out_tag), 64'(exp_tag[0]));
        req_valid = 3'b000;

        // Round-robin stream with all sources valid
        do_reset();
        req_valid = 3'b111;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1 check_eq($sformatf("t2 req_ready%0d", k), 64'(req_ready), 64'(3'b001 << (k % 3)));
            @(negedge clk);
            check_out($sformatf("t2 cyc%0d", k), k % 3);
        end

        // Backpressure for 4 cycles, then same-cycle drain and refill
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1 check_eq($sformatf("t3 stall req_ready%0d", k), 64'(req_ready), 64'd0);
            @(negedge clk);
            check_out($sformatf("t3 stall%0d", k), 2);
            check_eq($sformatf("t3 stall tag%0d", k), 64'(out_tag), 64'(exp_tag[2]));
        end
        out_ready = 1'b1;
        #1 check_eq("t3 refill req_ready", 64'(req_ready), 64'b001);
        @(negedge clk);
        check_out("t3 refill", 0);

        // Move pointer to 2, then 3'b011 must grant 0 then 1
        req_valid = 3'b010;
        @(negedge clk);
        check_out("t4 prep", 1);
        req_valid = 3'b011;
        #1 check_eq("t4 req_ready a", 64'(req_ready), 64'b001);
        @(negedge clk);
        check_out("t4 a", 0);
        #1 check_eq("t4 req_ready b", 64'(req_ready), 64'b010);
        @(negedge clk);
        check_out("t4 b", 1);

        // Source 2 with NV flag and maximum tag, then drain to empty
        req_valid = 3'b100;
        @(negedge clk);
        check_out("t5", 2);
        check_eq("t5 out_flags", 64'(out_flags), 64'b10000);
        check_eq("t5 out_tag",   64'(out_tag),   64'd31);
        req_valid = 3'b000;
        @(negedge clk);
        check_eq("t5 drain out_valid", 64'(out_valid), 64'd0);

        // Asynchronous reset while holding a result
        req_valid = 3'b010;
        @(negedge clk);
        check_out("t6 hold", 1);
        req_valid = 3'b000;
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        req_valid = 3'b111;
        #1;
        check_eq("t6 async out_valid", 64'(out_valid), 64'd0);
        check_eq("t6 async out_data",  64'(out_data),  64'd0);
        check_eq("t6 async out_tag",   64'(out_tag),   64'd0);
        check_eq("t6 async out_flags", 64'(out_flags), 64'd0);
        check_eq("t6 async out_src",   64'(out_src),   64'd0);
        check_eq("t6 async req_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1 check_eq("t6 first req_ready", 64'(req_ready), 64'b001);
        @(negedge clk);
        check_out("t6 first", 0);
        check_eq("t6 first flags", 64'(out_flags), 64'(exp_flg[0]));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/fpu_wb_arbiter.md
FPU_WB_ARBITER -- requirements
Module: fpu_wb_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 3: number of FPU result sources (0=add/sub, 1=mul, 2=div/sqrt).
REQ-002 SHALL have parameter TAG_W, default 5: destination-register tag width.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port req_valid, input, N_REQ: source i has a result pending.
REQ-006 SHALL have port req_ready, output, N_REQ: source i result accepted this cycle.
REQ-007 SHALL have port req_sign, input, N_REQ: per-source sign bit.
REQ-008 SHALL have port req_exp, input, 8*N_REQ: per-source biased exponent, source i at [8i+7:8i].
REQ-009 SHALL have port req_man, input, 23*N_REQ: per-source mantissa without hidden bit, source i at [23i+22:23i].
REQ-010 SHALL have port req_tag, input, TAG_W*N_REQ: per-source destination tag.
REQ-011 SHALL have port req_flags, input, 5*N_REQ: per-source IEEE flags {NV,DZ,OF,UF,NX}.
REQ-012 SHALL have port out_valid, output, 1: packed result held in the output register.
REQ-013 SHALL have port out_ready, input, 1: writeback consumes the result this cycle.
REQ-014 SHALL have port out_data, output, 32: packed IEEE 754 single {sign, exp, man}.
REQ-015 SHALL have ports out_tag (output, TAG_W), out_flags (output, 5) and out_src (output, 2): tag, flags and source index of the held result.

Function
REQ-016 SHALL compute load = !out_valid || out_ready; a new result is accepted only when load=1.
REQ-017 SHALL arbitrate round-robin: grant the lowest index j, searched cyclically from rr_ptr, with req_valid[j]=1.
REQ-018 SHALL drive req_ready[j]=1 only for the granted j, only when load=1; all other bits 0 (one-hot or zero).
REQ-019 SHALL, on a handshake with source j, register {req_sign[j], req_exp[j], req_man[j]} packed as out_data, plus tag, flags and src=j, and set out_valid=1 the next cycle (latency 1).
REQ-020 SHALL advance rr_ptr to (j+1) mod N_REQ on each handshake; rr_ptr SHALL hold when no handshake occurs.
REQ-021 SHALL hold out_data/out_tag/out_flags/out_src stable while out_valid=1 and out_ready=0.
REQ-022 SHALL clear out_valid when out_ready=1 and no request is valid; SHALL keep out_valid=1 when drain and refill occur in the same cycle (full throughput, 1 result/cycle).
REQ-023 SHALL treat req_ready as combinational from req_valid, out_valid and out_ready; req_valid/req_* SHALL not depend on req_ready (sources hold valid and data until accepted).
REQ-024 SHALL pass exponent, mantissa and flags bit-exact; no rounding, normalisation or special-value rewriting.
REQ-025 SHALL guarantee that any source with req_valid held high is granted within N_REQ handshakes (no starvation).

Reset
REQ-026 SHALL, while rst_n=0, force out_valid=0, out_data=0, out_tag=0, out_flags=0, out_src=0, rr_ptr=0, independent of clk.
REQ-027 SHALL drive req_ready=0 while rst_n=0; a result mid-hold is discarded on reset.
REQ-028 SHALL resume arbitration on the first rising clk edge after rst_n deasserts, starting from source 0.

Structure
REQ-029 SHALL place N_REQ default, TAG_W default, source-index constants (SRC_ADD=0, SRC_MUL=1, SRC_DIV=2) and flag bit positions in the shared FPU package.
REQ-030 SHALL instantiate the existing fpu_pack sub-module once, fed by the granted source's fields, to form out_data.
REQ-031 SHALL keep arbitration, rr_ptr and the output register in this module; no additional sub-modules.

Verification
REQ-032 SHALL check: reset, then req_valid=3'b001 with sign=1, exp=8'h80, man=23'h400000, out_ready=1 -> next cycle out_valid=1, out_data=32'hC0400000, out_src=0.
REQ-033 SHALL check: req_valid=3'b111 held, out_ready=1 -> grants 0,1,2,0,... on consecutive cycles; out_valid stays 1.
REQ-034 SHALL check: out_valid=1, out_ready=0 for 4 cycles with new requests -> req_ready=0, outputs unchanged; out_ready=1 -> same-cycle refill.
REQ-035 SHALL check: rr_ptr=2, req_valid=3'b011 -> grant source 0, then 1.
REQ-036 SHALL check: rst_n low mid-hold (out_valid=1) -> outputs 0 asynchronously; after release, first grant from source 0.
REQ-037 SHALL check: flags 5'b10000 and tag 5'd31 on source 2 -> out_flags=5'b10000, out_tag=31, out_src=2.
